// File: rtl/spi_frame_receiver.sv
// SPI frame receiver: synchronises raw SPI pins into clk, detects SCLK/nCS
// edges, shifts in MSB-first frames and emits one-cycle valid/err pulses
// carrying the decoded R/W, address and data fields.
module spi_frame_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       copi_in,
    input  logic       ncs_in,
    output logic       frame_valid,
    output logic       frame_write,
    output logic [6:0] frame_addr,
    output logic [7:0] frame_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W   = $clog2(FRAME_BITS + 1);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic [FLUSH_W-1:0]     flush;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   edge_en, sclk_rise, ncs_fall, ncs_rise;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_BITS-1:0]  shreg;
    logic                   overrun;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];

    // Edges are suppressed until the chains have flushed after reset, so a
    // pin that is already low at release never looks like a fresh nCS fall.
    assign edge_en   = (flush == '0);
    assign sclk_rise = edge_en & sclk_s & ~sclk_d;
    assign ncs_fall  = edge_en & ~ncs_s & ncs_d;
    assign ncs_rise  = edge_en & ncs_s & ~ncs_d;

    assign busy = (state != IDLE);

    // Synchroniser chains, edge-history flops and post-reset flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
            flush     <= FLUSH_W'(SYNC_STAGES + 1);
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
            if (flush != '0)
                flush <= flush - 1'b1;
        end
    end

    // Frame FSM: shifting, overrun tracking and registered decode outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            overrun     <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_write <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A coincident sclk_rise is deliberately dropped here
                    if (ncs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        overrun <= 1'b0;
                    end
                end
                SHIFT: begin
                    // nCS rising before all bits arrived wins over any sclk edge
                    if (ncs_rise) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], copi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt + 1'b1 == CNT_W'(FRAME_BITS))
                            state <= FULL;
                    end
                end
                FULL: begin
                    if (ncs_rise) begin
                        state <= IDLE;
                        if (overrun || (shreg[FRAME_BITS-2:8] > 7'(MAX_ADDR))) begin
                            frame_err <= 1'b1;
                        end else begin
                            frame_valid <= 1'b1;
                            frame_write <= shreg[FRAME_BITS-1];
                            frame_addr  <= shreg[FRAME_BITS-2:8];
                            frame_data  <= shreg[7:0];
                        end
                    end else if (sclk_rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
